seq_controle_ula: RTL and testbench



---
 rtl/ctrl_pkg.sv | 31 +++
 rtl/dec_op_ula.sv | 34 +++
 rtl/seq_controle_ula.sv | 122 ++++++++++++
 tb/tb_seq_controle_ula.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared codes for the X/Y/Z register + ULA datapath and the sequencer state encoding.
package ctrl_pkg;

  localparam logic [3:0] REG_CLEAR  = 4'd0;
  localparam logic [3:0] REG_LOAD   = 4'd1;
  localparam logic [3:0] REG_HOLD   = 4'd2;
  localparam logic [3:0] REG_SHIFTR = 4'd3;

  localparam logic [3:0] ULA_ADD = 4'd0;
  localparam logic [3:0] ULA_SUB = 4'd1;
  localparam logic [3:0] ULA_AND = 4'd2;
  localparam logic [3:0] ULA_OR  = 4'd3;

  localparam logic [2:0] OP_ADD    = 3'b000;
  localparam logic [2:0] OP_SUB    = 3'b001;
  localparam logic [2:0] OP_AND    = 3'b010;
  localparam logic [2:0] OP_OR     = 3'b011;
  localparam logic [2:0] OP_SHRADD = 3'b100;
  localparam logic [2:0] OP_CLRALL = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LDX  = 3'd1,
    S_LDY  = 3'd2,
    S_SHR  = 3'd3,
    S_EXEC = 3'd4,
    S_CLR  = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/dec_op_ula.sv
// Opcode decoder: maps an opcode to its ULA code and the sequencing class flags.
module dec_op_ula
  import ctrl_pkg::*;
#(
  parameter int W_CTRL = 4,
  parameter int W_OP   = 3
) (
  input  logic [W_OP-1:0]   op,
  output logic [W_CTRL-1:0] tula,
  output logic              is_shift,
  output logic              is_clr,
  output logic              is_illegal
);

  always_comb begin
    tula       = ULA_ADD;
    is_shift   = 1'b0;
    is_clr     = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_ADD:    tula = ULA_ADD;
      OP_SUB:    tula = ULA_SUB;
      OP_AND:    tula = ULA_AND;
      OP_OR:     tula = ULA_OR;
      OP_SHRADD: begin
        tula     = ULA_ADD;
        is_shift = 1'b1;
      end
      OP_CLRALL: is_clr = 1'b1;
      default:   is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/seq_controle_ula.sv
// Start/done sequencer issuing per-cycle register and ULA control codes for one opcode.
module seq_controle_ula
  import ctrl_pkg::*;
#(
  parameter int W_CTRL      = 4,
  parameter int W_OP        = 3,
  parameter int SHIFT_COUNT = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [W_OP-1:0]   opcode,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [W_CTRL-1:0] tx,
  output logic [W_CTRL-1:0] ty,
  output logic [W_CTRL-1:0] tz,
  output logic [W_CTRL-1:0] tula
);

  localparam logic [2:0] SHIFT_INIT = 3'(SHIFT_COUNT);

  state_t          state, state_nx;
  logic [2:0]      cnt, cnt_nx;
  logic [W_OP-1:0] op_q, op_nx;
  logic            ill_q, ill_nx;

  logic [W_OP-1:0]   dec_in;
  logic [W_CTRL-1:0] dec_tula;
  logic              dec_shift, dec_clr, dec_illegal;

  // In IDLE the incoming opcode is classified for the accept decision; afterwards the latched one.
  assign dec_in = (state == S_IDLE) ? opcode : op_q;

  dec_op_ula #(.W_CTRL(W_CTRL), .W_OP(W_OP)) u_dec (
    .op         (dec_in),
    .tula       (dec_tula),
    .is_shift   (dec_shift),
    .is_clr     (dec_clr),
    .is_illegal (dec_illegal)
  );

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    op_nx    = op_q;
    ill_nx   = ill_q;
    case (state)
      S_IDLE: if (start) begin
        op_nx  = opcode;
        ill_nx = dec_illegal;
        if (dec_illegal)  state_nx = S_DONE;
        else if (dec_clr) state_nx = S_CLR;
        else              state_nx = S_LDX;
      end
      S_LDX: state_nx = S_LDY;
      S_LDY: if (dec_shift) begin
        state_nx = S_SHR;
        cnt_nx   = SHIFT_INIT;
      end else begin
        state_nx = S_EXEC;
      end
      S_SHR: begin
        cnt_nx = cnt - 3'd1;
        if (cnt == 3'd1) state_nx = S_EXEC;
      end
      S_EXEC: state_nx = S_DONE;
      S_CLR:  state_nx = S_DONE;
      S_DONE: begin
        state_nx = S_IDLE;
        ill_nx   = 1'b0;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one lines up with the state it belongs to.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
      op_q  <= '0;
      ill_q <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
      tx    <= REG_HOLD;
      ty    <= REG_HOLD;
      tz    <= REG_HOLD;
      tula  <= ULA_ADD;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      op_q  <= op_nx;
      ill_q <= ill_nx;
      busy  <= (state_nx != S_IDLE);
      done  <= (state_nx == S_DONE);
      err   <= (state_nx == S_DONE) && ill_nx;
      tx    <= REG_HOLD;
      ty    <= REG_HOLD;
      tz    <= REG_HOLD;
      tula  <= ULA_ADD;
      case (state_nx)
        S_LDX: tx <= REG_LOAD;
        S_LDY: ty <= REG_LOAD;
        S_SHR: ty <= REG_SHIFTR;
        S_EXEC: begin
          tz   <= REG_LOAD;
          tula <= dec_tula;
        end
        S_CLR: begin
          tx <= REG_CLEAR;
          ty <= REG_CLEAR;
          tz <= REG_CLEAR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_controle_ula.sv
// Directed bench for seq_controle_ula: expected per-cycle outputs queued at launch, popped each cycle.
module tb_seq_controle_ula;

  localparam int SC = 3;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic [2:0] opcode;
  logic       busy, done, err;
  logic [3:0] tx, ty, tz, tula;

  always #5 clock = ~clock;

  seq_controle_ula #(.W_CTRL(4), .W_OP(3), .SHIFT_COUNT(SC)) dut (
    .clock  (clock),
    .reset  (reset),
    .start  (start),
    .opcode (opcode),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .tx     (tx),
    .ty     (ty),
    .tz     (tz),
    .tula   (tula)
  );

  initial begin
    if (SC < 1 || SC > 7) $fatal(1, "FAIL cfg SHIFT_COUNT=%0d outside 1..7", SC);
  end

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] tx;
    logic [3:0] ty;
    logic [3:0] tz;
    logic [3:0] tula;
  } obs_t;

  obs_t now_obs;
  assign now_obs = {busy, done, err, tx, ty, tz, tula};

  obs_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic obs_t mk(logic b, logic d, logic e,
                              logic [3:0] x, logic [3:0] y, logic [3:0] z, logic [3:0] u);
    obs_t o;
    o.busy = b; o.done = d; o.err = e;
    o.tx = x; o.ty = y; o.tz = z; o.tula = u;
    return o;
  endfunction

  obs_t idle_o;
  initial idle_o = mk(1'b0, 1'b0, 1'b0, 4'd2, 4'd2, 4'd2, 4'd0);

  task automatic chk(input string tag, input obs_t exp);
    n_tests++;
    assert (now_obs === exp) else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h", tag, now_obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Reference sequence for one transaction, followed by the IDLE cycle it returns to.
  task automatic push_op(input logic [2:0] op);
    logic [3:0] u;
    if (op >= 3'd6) begin
      q.push_back(mk(1, 1, 1, 4'd2, 4'd2, 4'd2, 4'd0));
    end else if (op == 3'd5) begin
      q.push_back(mk(1, 0, 0, 4'd0, 4'd0, 4'd0, 4'd0));
      q.push_back(mk(1, 1, 0, 4'd2, 4'd2, 4'd2, 4'd0));
    end else begin
      u = (op == 3'd4) ? 4'd0 : {1'b0, op};
      q.push_back(mk(1, 0, 0, 4'd1, 4'd2, 4'd2, 4'd0));
      q.push_back(mk(1, 0, 0, 4'd2, 4'd1, 4'd2, 4'd0));
      if (op == 3'd4) repeat (SC) q.push_back(mk(1, 0, 0, 4'd2, 4'd3, 4'd2, 4'd0));
      q.push_back(mk(1, 0, 0, 4'd2, 4'd2, 4'd1, u));
      q.push_back(mk(1, 1, 0, 4'd2, 4'd2, 4'd2, 4'd0));
    end
    q.push_back(idle_o);
  endtask

  task automatic drain(input string tag, input bit hold, input int pulse_at, input int exp_lat);
    int   k;
    int   lat;
    obs_t e;
    k   = 0;
    lat = -1;
    while (q.size() > 0) begin
      step();
      k++;
      e = q.pop_front();
      chk(tag, e);
      if (done === 1'b1 && lat < 0) lat = k;
      if (!hold) start = 1'b0;
      if (k == pulse_at) begin
        start  = 1'b1;
        opcode = 3'b011;
      end
    end
    start = 1'b0;
    n_tests++;
    assert (lat === exp_lat) else begin
      n_fail++;
      $error("FAIL %s_latency got=%0d exp=%0d", tag, lat, exp_lat);
    end
  endtask

  task automatic launch(input logic [2:0] op);
    start  = 1'b1;
    opcode = op;
  endtask

  initial begin
    reset  = 1'b1;
    start  = 1'b0;
    opcode = 3'b000;
    repeat (3) begin
      step();
      chk("reset_held", idle_o);
    end
    reset = 1'b0;
    repeat (2) begin
      step();
      chk("idle_after_reset", idle_o);
    end

    launch(3'b001); push_op(3'b001); drain("sub", 1'b0, 0, 4);
    launch(3'b000); push_op(3'b000); drain("add", 1'b0, 0, 4);
    launch(3'b010); push_op(3'b010); drain("and", 1'b0, 0, 4);
    launch(3'b011); push_op(3'b011); drain("or", 1'b0, 0, 4);
    launch(3'b100); push_op(3'b100); drain("shradd", 1'b0, 0, 4 + SC);
    launch(3'b101); push_op(3'b101); drain("clrall", 1'b0, 0, 2);
    launch(3'b110); push_op(3'b110); drain("illegal110", 1'b0, 0, 1);
    launch(3'b111); push_op(3'b111); drain("illegal111", 1'b0, 0, 1);

    // start held high: second ADD launches right after the single IDLE cycle
    launch(3'b000); push_op(3'b000); push_op(3'b000); drain("b2b_add", 1'b1, 0, 4);

    // start + OR opcode pulsed during LDY must not disturb the running ADD
    launch(3'b000); push_op(3'b000); drain("busy_start_ignored", 1'b0, 2, 4);

    // async reset during EXEC: outputs drop without a clock edge, no done pulse follows
    launch(3'b000);
    q.push_back(mk(1, 0, 0, 4'd1, 4'd2, 4'd2, 4'd0));
    q.push_back(mk(1, 0, 0, 4'd2, 4'd1, 4'd2, 4'd0));
    q.push_back(mk(1, 0, 0, 4'd2, 4'd2, 4'd1, 4'd0));
    drain("pre_reset_add", 1'b0, 0, -1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_exec", idle_o);
    step();
    chk("reset_held_exec", idle_o);
    reset = 1'b0;
    repeat (3) begin
      step();
      chk("no_done_after_reset", idle_o);
    end

    launch(3'b010); push_op(3'b010); drain("and_after_reset", 1'b0, 0, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
